seg_fade_pwm: RTL and testbench

// - Downstream stage of the 7-segment snake: takes the raw 8-bit segment pattern (a..g, dp) and drives the pads.
// - Each segment gets a per-segment brightness level with a PWM output.
// - A lit segment jumps to full brightness. When it goes dark it decays one step per decay strobe, leaving a fading afterglow trail behind the snake.
// - Sits between the snake core and uo_out[7:0].

---
 rtl/seg_fade_pkg.sv | 37 +++
 rtl/seg_fade_chan.sv | 59 +++++
 rtl/seg_fade_pwm.sv | 95 +++++++++
 tb/tb_seg_fade_pwm.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_fade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_fade_pkg
//  Description : Shared constants and types for the segment afterglow PWM
//                stage that sits between the snake core and the pads.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_fade_pkg;

  // Channel count and brightness resolution
  localparam int NSEG    = 8;
  localparam int LVL_W   = 4;
  localparam int LVL_MAX = (1 << LVL_W) - 1;

  // Segment bit positions, matching the uo_out bit order
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [LVL_W-1:0] level_t;
  typedef logic [NSEG-1:0]  seg_vec_t;

  // One decay step that saturates at zero instead of wrapping to LVL_MAX
  function automatic level_t lvl_dec(input level_t lvl);
    if (lvl == '0) begin
      return '0;
    end
    return lvl - level_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_fade_chan.sv
`default_nettype none
// ============================================================================
//  Module      : seg_fade_chan
//  Description : One segment channel: brightness level register with
//                lit-refresh / decay behaviour and a registered PWM compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_fade_chan
  import seg_fade_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lit,
  input  logic             fade_en,
  input  logic             decay_stb,
  input  logic [LVL_W-1:0] pwm_cnt,
  output logic             drive
);

  level_t level_q;
  level_t level_d;
  logic   drive_q;
  logic   drive_d;

  // Level priority: a lit segment always refreshes to full, even on a strobe;
  // with afterglow disabled an unlit segment goes dark at once; otherwise the
  // level steps down one notch per strobe and rests at zero.
  always_comb begin
    level_d = level_q;
    if (lit) begin
      level_d = level_t'(LVL_MAX);
    end else if (!fade_en) begin
      level_d = '0;
    end else if (decay_stb) begin
      level_d = lvl_dec(level_q);
    end
  end

  // PWM compare: level L is high for counts 0..L-1, giving L/LVL_MAX duty;
  // full level is steady high because pwm_cnt never reaches LVL_MAX.
  always_comb begin
    drive_d = (level_q > pwm_cnt);
  end

  // Level and pad-drive flops; reset clears any residual glow immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      drive_q <= 1'b0;
    end else begin
      level_q <= level_d;
      drive_q <= drive_d;
    end
  end

  assign drive = drive_q;

endmodule
`default_nettype wire

// File: rtl/seg_fade_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : seg_fade_pwm
//  Description : Segment afterglow stage. Registers the raw snake pattern,
//                runs the shared PWM counter and decay prescaler, and fans
//                out to one fading PWM channel per segment.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_fade_pwm
  import seg_fade_pkg::*;
#(
  parameter int DECAY_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSEG-1:0] seg_in,
  input  logic            fade_en,
  input  logic [1:0]      decay_sel,
  output logic [NSEG-1:0] seg_out,
  output logic            pwm_wrap
);

  // rst_n is released synchronously by the upstream reset tree, so the
  // asynchronous clear here only has to handle assertion.

  seg_vec_t            seg_q;
  level_t              pwm_cnt_q;
  level_t              pwm_cnt_d;
  logic                pwm_wrap_q;
  logic                pwm_wrap_d;
  logic [DECAY_W-1:0]  presc_q;
  logic [DECAY_W-1:0]  presc_d;
  logic [DECAY_W-1:0]  stb_mask;
  logic                decay_stb;

  // PWM counter runs 0..LVL_MAX-1 so the period is LVL_MAX cycles and the
  // full level compares high on every count.
  always_comb begin
    if (pwm_cnt_q == level_t'(LVL_MAX - 1)) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + level_t'(1);
    end
    pwm_wrap_d = (pwm_cnt_q == level_t'(LVL_MAX - 1));
  end

  // Prescaler free-runs and wraps naturally at 2**DECAY_W
  always_comb begin
    presc_d = presc_q + DECAY_W'(1);
  end

  // Strobe mask selects the low DECAY_W-3+decay_sel prescaler bits; the
  // select is used live, so a change applies at the next evaluation.
  always_comb begin
    stb_mask = '0;
    for (int b = 0; b < DECAY_W; b++) begin
      stb_mask[b] = (b < (DECAY_W - 3 + int'(decay_sel)));
    end
  end

  // Strobe fires when every selected prescaler bit is one
  assign decay_stb = &(presc_q | ~stb_mask);

  // Stage 1 capture plus the shared timebase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= '0;
      pwm_cnt_q  <= '0;
      pwm_wrap_q <= 1'b0;
      presc_q    <= '0;
    end else begin
      seg_q      <= seg_in;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_wrap_q <= pwm_wrap_d;
      presc_q    <= presc_d;
    end
  end

  assign pwm_wrap = pwm_wrap_q;

  // One identical channel per segment, dp included
  for (genvar gi = 0; gi < NSEG; gi++) begin : g_chan
    seg_fade_chan u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .lit       (seg_q[gi]),
      .fade_en   (fade_en),
      .decay_stb (decay_stb),
      .pwm_cnt   (pwm_cnt_q),
      .drive     (seg_out[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_fade_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_fade_pwm
//  Description : Self-checking bench for seg_fade_pwm against a cycle-count
//                based reference model of levels, duty and timebase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_fade_pwm;

  localparam int DECAY_W = 6;
  localparam int PERIOD  = 15;   // PWM period = LVL_MAX
  localparam int FULL    = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic       fade_en = 1'b0;
  logic [1:0] decay_sel = 2'd0;
  logic [7:0] seg_out;
  logic       pwm_wrap;

  seg_fade_pwm #(.DECAY_W(DECAY_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .fade_en   (fade_en),
    .decay_sel (decay_sel),
    .seg_out   (seg_out),
    .pwm_wrap  (pwm_wrap)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: n = edges since reset; PWM phase is n mod 15 and the
  // prescaler is n mod 2**DECAY_W, so both come from plain arithmetic.
  int       m_n;
  bit [7:0] m_seg;
  int       m_lvl [8];
  bit [7:0] m_out;
  bit       m_wrap;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_strobe(input int n, input int sel);
    int p;
    p = 1 << (DECAY_W - 3 + sel);
    return (n % p) == (p - 1);
  endfunction

  task automatic model_reset();
    m_n = 0; m_seg = '0; m_out = '0; m_wrap = 1'b0;
    for (int i = 0; i < 8; i++) m_lvl[i] = 0;
  endtask

  // Advance model and DUT by one clock edge, then compare outputs
  task automatic step();
    int ph;
    bit stb;
    if (!rst_n) begin
      model_reset();
    end else begin
      ph  = m_n % PERIOD;
      stb = m_strobe(m_n, int'(decay_sel));
      for (int i = 0; i < 8; i++) begin
        m_out[i] = (m_lvl[i] > ph);
        if (m_seg[i])                  m_lvl[i] = FULL;
        else if (!fade_en)             m_lvl[i] = 0;
        else if (stb && m_lvl[i] > 0)  m_lvl[i] = m_lvl[i] - 1;
      end
      m_wrap = (ph == PERIOD - 1);
      m_seg  = seg_in;
      m_n++;
    end
    @(posedge clk); #1;
    check("seg_out", int'(seg_out), int'(m_out));
    check("pwm_wrap", int'(pwm_wrap), int'(m_wrap));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wraps;
    int seen [$];
    int last;
    bit found;
    model_reset();

    // Reset held with everything lit
    rst_n = 1'b0; seg_in = 8'hFF; fade_en = 1'b1;
    repeat (3) step();
    check("rst_seg_out", int'(seg_out), 0);
    check("rst_wrap", int'(pwm_wrap), 0);

    // Release with nothing lit: stays dark
    rst_n = 1'b1; seg_in = 8'h00;
    for (int k = 0; k < 100; k++) begin
      step();
      check("idle_dark", int'(seg_out), 0);
    end

    // Full on for segment a
    seg_in = 8'h01; decay_sel = 2'd0; wraps = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (pwm_wrap) wraps++;
      if (k >= 2) check("full_on_bit0", int'(seg_out[0]), 1);
      check("full_on_others", int'(seg_out[7:1]), 0);
    end
    check("wrap_count", wraps, 4);

    // Fade of segment a at the fastest rate
    seg_in = 8'h00;
    last = FULL; seen.push_back(FULL);
    for (int k = 0; k < 135; k++) begin
      step();
      if (int'(dut.g_chan[0].u_chan.level_q) != last) begin
        last = int'(dut.g_chan[0].u_chan.level_q);
        seen.push_back(last);
      end
    end
    check("fade_steps", seen.size(), FULL + 1);
    for (int j = 0; j < seen.size() && j <= FULL; j++) check("fade_seq", seen[j], FULL - j);
    for (int k = 0; k < 30; k++) begin
      step();
      check("faded_dark", int'(seg_out[0]), 0);
    end

    // Collision: segment d relit on the same edge as a strobe at level 9
    seg_in = 8'h08; repeat (4) step();
    seg_in = 8'h00; found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (m_lvl[3] == 9 && m_strobe(m_n + 1, 0)) begin found = 1'b1; break; end
      step();
    end
    check("collision_found", int'(found), 1);
    seg_in = 8'h08;
    step(); step();
    check("collision_lvl", int'(dut.g_chan[3].u_chan.level_q), FULL);
    repeat (4) step();

    // fade_en dropped while a fades at level 7, dp held lit
    seg_in = 8'h81; repeat (4) step();
    seg_in = 8'h80; found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (m_lvl[0] == 7) begin found = 1'b1; break; end
      step();
    end
    check("fe_found", int'(found), 1);
    fade_en = 1'b0;
    step();
    check("fe_off_lvl", int'(dut.g_chan[0].u_chan.level_q), 0);
    step();
    check("fe_off_out", int'(seg_out[0]), 0);
    check("fe_lit_steady", int'(seg_out[7]), 1);
    repeat (20) step();
    fade_en = 1'b1;

    // Asynchronous reset pulse mid-fade at level 10
    seg_in = 8'h04; repeat (4) step();
    seg_in = 8'h00; found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (m_lvl[2] == 10) begin found = 1'b1; break; end
      step();
    end
    check("arst_found", int'(found), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out", int'(seg_out), 0);
    check("arst_wrap", int'(pwm_wrap), 0);
    check("arst_lvl", int'(dut.g_chan[2].u_chan.level_q), 0);
    #4 rst_n = 1'b1;
    model_reset();
    step();
    check("arst_lvl_after", int'(dut.g_chan[2].u_chan.level_q), 0);

    // Randomized traffic across patterns, rates and afterglow mode
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(3, 0) == 0)  seg_in = 8'($urandom);
      if ($urandom_range(59, 0) == 0) fade_en = ~fade_en;
      if ($urandom_range(39, 0) == 0) decay_sel = 2'($urandom_range(3, 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
